// File: rtl/ascon_pkg.sv
// Shared types and constants for the Ascon permutation control path.
// Holds round-mode and sequencer-state encodings plus the first-round lookup.
package ascon_pkg;

  localparam int NUM_ROUNDS = 12;

  typedef enum logic [1:0] {
    P12 = 2'b00,
    P8  = 2'b01,
    P6  = 2'b10
  } t_round_mode;

  localparam logic [3:0] ROUND_FIRST_P12 = 4'd0;
  localparam logic [3:0] ROUND_FIRST_P8  = 4'd4;
  localparam logic [3:0] ROUND_FIRST_P6  = 4'd6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_ROUND = 2'b10,
    ST_DONE  = 2'b11
  } t_ctrl_fsm;

  // Shorter permutations run the tail of the constant table; the reserved
  // encoding 2'b11 falls back to the full p12 schedule.
  function automatic logic [3:0] first_round(input logic [1:0] mode);
    logic [3:0] first;
    case (mode)
      P8:      first = ROUND_FIRST_P8;
      P6:      first = ROUND_FIRST_P6;
      default: first = ROUND_FIRST_P12;
    endcase
    return first;
  endfunction

endpackage

// File: rtl/ascon_round_ctrl_round_counter.sv
// Loadable 4-bit round counter with enable and terminal-count flag.
// Saturates at LAST so the round index can never wrap past the constant table.
module round_counter #(
  parameter int LAST = 11
) (
  input  logic       i_clock,
  input  logic       i_reset_n,
  input  logic       i_load,
  input  logic [3:0] i_load_value,
  input  logic       i_en,
  output logic [3:0] o_count,
  output logic       o_last
);

  logic [3:0] count_q;

  // NOTE: reset is asynchronous so the counter clears even without a running clock.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      count_q <= 4'd0;
    end else if (i_load) begin
      // NOTE: non-blocking assignment keeps every flop updating from pre-edge values.
      count_q <= i_load_value;
    end else if (i_en && !o_last) begin
      count_q <= count_q + 4'd1;
    end
  end

  assign o_count = count_q;
  assign o_last  = (count_q == 4'(LAST));

endmodule

// File: rtl/ascon_round_ctrl.sv
// Round sequencer for the Ascon permutation: loads the state register, then
// steps one round per cycle through p12/p8/p6 and pulses done at the end.
module ascon_round_ctrl #(
  parameter int NUM_ROUNDS = ascon_pkg::NUM_ROUNDS
) (
  input  logic       i_clock,
  input  logic       i_reset_n,
  input  logic       i_start,
  input  logic [1:0] i_mode,
  input  logic       i_stall,
  input  logic       i_abort,
  output logic [3:0] o_round,
  output logic       o_state_sel,
  output logic       o_state_en,
  output logic       o_busy,
  output logic       o_done
);
  import ascon_pkg::*;

  t_ctrl_fsm  state_q;
  t_ctrl_fsm  state_d;
  logic       accept;
  logic       cnt_en;
  logic [3:0] count;
  logic       count_last;

  // A new permutation may only begin while no run is in flight; abort wins.
  assign accept = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && i_start && !i_abort;
  assign cnt_en = (state_q == ST_ROUND) && !i_stall;

  round_counter #(
    .LAST(NUM_ROUNDS - 1)
  ) u_round_counter (
    .i_clock     (i_clock),
    .i_reset_n   (i_reset_n),
    .i_load      (accept),
    .i_load_value(first_round(i_mode)),
    .i_en        (cnt_en),
    .o_count     (count),
    .o_last      (count_last)
  );

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    state_d     = state_q;
    o_round     = count;
    o_state_sel = 1'b0;
    o_state_en  = 1'b0;
    o_busy      = 1'b0;
    o_done      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        o_state_en = 1'b1;
        o_busy     = 1'b1;
        state_d    = ST_ROUND;
      end
      ST_ROUND: begin
        o_state_sel = 1'b1;
        o_state_en  = !i_stall;
        o_busy      = 1'b1;
        if (!i_stall && count_last) state_d = ST_DONE;
      end
      ST_DONE: begin
        o_done  = 1'b1;
        state_d = accept ? ST_LOAD : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (i_abort) state_d = ST_IDLE;
  end

endmodule

// File: tb/tb_ascon_round_ctrl.sv
// Self-checking bench for ascon_round_ctrl: per-cycle expectation traces built
// from the round schedule, applied by table, plus abort/reset sequences.
module tb_ascon_round_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       stall = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] round;
  logic       sel, en, busy, done;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  ascon_round_ctrl dut (
    .i_clock    (clk),
    .i_reset_n  (rst_n),
    .i_start    (start),
    .i_mode     (mode),
    .i_stall    (stall),
    .i_abort    (abort),
    .o_round    (round),
    .o_state_sel(sel),
    .o_state_en (en),
    .o_busy     (busy),
    .o_done     (done)
  );

  typedef struct {
    logic       start;
    logic [1:0] mode;
    logic       stall;
    logic       abort;
    logic [3:0] round;
    logic       sel;
    logic       en;
    logic       busy;
    logic       done;
    logic       chk_round;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got {round,sel,en,busy,done}=%h expected %h", name, got, exp);
  endtask

  function automatic vec_t mk(input logic st, input logic [1:0] m, input logic sl, input logic ab,
                              input logic [3:0] r, input logic s, input logic e, input logic b,
                              input logic d, input logic c);
    vec_t v;
    v.start = st; v.mode = m; v.stall = sl; v.abort = ab;
    v.round = r; v.sel = s; v.en = e; v.busy = b; v.done = d; v.chk_round = c;
    return v;
  endfunction

  // Number of rounds per mode; the run always ends on the last constant (11).
  function automatic int first_of(input logic [1:0] m);
    int rounds;
    rounds = (m == 2'b01) ? 8 : (m == 2'b10) ? 6 : 12;
    return 12 - rounds;
  endfunction

  task automatic push_quiet(input logic st, input logic [1:0] m, input logic sl, input logic ab,
                            input logic c);
    tbl.push_back(mk(st, m, sl, ab, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, c));
  endtask

  // stall_mode: 0 none, 1 stall_len cycles at stall_round, 2 random stalls.
  task automatic add_run(input logic [1:0] m, input int stall_mode, input int stall_round,
                         input int stall_len, input logic junk, input logic nxt_start,
                         input logic [1:0] nxt_mode);
    int f;
    int ns;
    f = first_of(m);
    tbl.push_back(mk(junk, ~m, junk, 1'b0, 4'(f), 1'b0, 1'b1, 1'b1, 1'b0, 1'b1));
    for (int r = f; r < 12; r++) begin
      ns = 0;
      if (stall_mode == 1 && r == stall_round) ns = stall_len;
      if (stall_mode == 2 && $urandom_range(0, 3) == 0) ns = $urandom_range(1, 3);
      for (int k = 0; k < ns; k++)
        tbl.push_back(mk(junk, ~m, 1'b1, 1'b0, 4'(r), 1'b1, 1'b0, 1'b1, 1'b0, 1'b1));
      tbl.push_back(mk(junk, ~m, 1'b0, 1'b0, 4'(r), 1'b1, 1'b1, 1'b1, 1'b0, 1'b1));
    end
    tbl.push_back(mk(nxt_start, nxt_mode, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
  endtask

  task automatic apply_row(input vec_t v, input string name);
    logic [7:0] got, exp;
    @(negedge clk);
    start = v.start; mode = v.mode; stall = v.stall; abort = v.abort;
    #1;
    got = {v.chk_round ? round : 4'h0, sel, en, busy, done};
    exp = {v.chk_round ? v.round : 4'h0, v.sel, v.en, v.busy, v.done};
    check(name, got, exp);
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < tbl.size(); i++)
      apply_row(tbl[i], $sformatf("%s_row%0d", tag, i));
    tbl.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [1:0] m, nm;
    logic       b2b;
    int         run_start, idx;

    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed table: reset idle, p12, p6 then back-to-back p8, stalled p12,
    // abort+start in idle, mode 11 with ignored mid-run starts.
    for (int i = 0; i < 5; i++) push_quiet(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    push_quiet(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    add_run(2'b00, 0, 0, 0, 1'b0, 1'b0, 2'b00);
    push_quiet(1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
    add_run(2'b10, 0, 0, 0, 1'b0, 1'b1, 2'b01);
    add_run(2'b01, 0, 0, 0, 1'b0, 1'b0, 2'b00);
    push_quiet(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    add_run(2'b00, 1, 5, 3, 1'b0, 1'b0, 2'b00);
    push_quiet(1'b1, 2'b00, 1'b1, 1'b1, 1'b0);
    push_quiet(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
    push_quiet(1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
    add_run(2'b11, 0, 0, 0, 1'b1, 1'b0, 2'b00);
    push_quiet(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    run_table("dir");

    // Abort while o_round=7: idle next cycle, no done pulse afterwards.
    apply_row(mk(1'b1, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "abort_start");
    apply_row(mk(1'b0, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1), "abort_load");
    for (int r = 0; r < 7; r++)
      apply_row(mk(1'b0, 2'b00, 1'b0, 1'b0, 4'(r), 1'b1, 1'b1, 1'b1, 1'b0, 1'b1),
                $sformatf("abort_round%0d", r));
    apply_row(mk(1'b0, 2'b00, 1'b0, 1'b1, 4'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1), "abort_round7");
    for (int i = 0; i < 4; i++)
      apply_row(mk(1'b0, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0),
                $sformatf("abort_after%0d", i));

    // Asynchronous reset while o_round=3.
    apply_row(mk(1'b1, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "rst_start");
    apply_row(mk(1'b0, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1), "rst_load");
    for (int r = 0; r < 4; r++)
      apply_row(mk(1'b0, 2'b00, 1'b0, 1'b0, 4'(r), 1'b1, 1'b1, 1'b1, 1'b0, 1'b1),
                $sformatf("rst_round%0d", r));
    #2 rst_n = 1'b0;
    #1 check("async_reset", {round, sel, en, busy, done}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++)
      apply_row(mk(1'b0, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1),
                $sformatf("rst_after%0d", i));

    // Randomized runs: modes, stalls, junk starts, aborts, back-to-back starts.
    m = 2'($urandom_range(0, 3));
    push_quiet(1'b1, m, 1'b0, 1'b0, 1'b0);
    for (int t = 0; t < 40; t++) begin
      nm  = 2'($urandom_range(0, 3));
      b2b = ($urandom_range(0, 2) == 0);
      run_start = tbl.size();
      add_run(m, 2, 0, 0, 1'($urandom_range(0, 1)), b2b, nm);
      if ($urandom_range(0, 4) == 0) begin
        idx = $urandom_range(run_start, tbl.size() - 2);
        tbl[idx].abort = 1'b1;
        while (tbl.size() > idx + 1) void'(tbl.pop_back());
        push_quiet(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        b2b = 1'b0;
      end
      if (!b2b) begin
        for (int g = $urandom_range(0, 2); g > 0; g--)
          push_quiet(1'b0, 2'b00, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        push_quiet(1'b1, nm, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      end
      m = nm;
    end
    run_table("rnd");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
